// File: rtl/spm_dac_pkg.sv
// Shared definitions for the SPM DAC serializer: frame layout, FSM states and
// the Q31 -> DAC code conversion (round to nearest, saturate positive overflow).
package spm_dac_pkg;

  localparam int unsigned FRAME_W = 32'd24;
  localparam int unsigned CMD_W   = 32'd4;
  localparam int unsigned CODE_W  = FRAME_W - CMD_W;

  localparam logic [CMD_W-1:0] CMD_WRITE = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_LDAC  = 3'd4
  } dac_state_e;

  // Returns the code left-aligned in CODE_W bits, so narrower DACs get zero LSB padding.
  function automatic logic [CODE_W-1:0] q31_to_code(input logic [31:0] d,
                                                    input int unsigned dac_bits,
                                                    input logic offset_bin);
    logic signed [32:0]  sum_v;
    logic signed [31:0]  sat_v;
    logic signed [31:0]  shr_v;
    logic [CODE_W-1:0]   code_v;
    sum_v = $signed({d[31], d}) + (33'sd1 <<< (32'd31 - dac_bits));
    // Only the positive side can overflow: the input is never below -2^31.
    if (sum_v > 33'sh0_7FFF_FFFF) begin
      sat_v = 32'sh7FFF_FFFF;
    end else begin
      sat_v = sum_v[31:0];
    end
    shr_v  = sat_v >>> (32'd32 - dac_bits);
    code_v = shr_v[CODE_W-1:0] << (CODE_W - dac_bits);
    code_v[CODE_W-1] = code_v[CODE_W-1] ^ offset_bin;
    return code_v;
  endfunction

endpackage

// File: rtl/axis_spm_dac_serializer_lane.sv
// One DAC lane: converts the channel sample to a frame and shifts it out MSB first.
module spm_dac_lane
  import spm_dac_pkg::*;
#(
  parameter int unsigned          DAC_BITS   = 32'd20,
  parameter int unsigned          OFFSET_BIN = 32'd0,
  parameter logic [FRAME_W-1:0]   CTRL_WORD  = 24'h200012
) (
  input  logic        a_clk,
  input  logic        a_resetn,
  input  logic [31:0] tdata,
  input  logic        load_ctrl,
  input  logic        load_data,
  input  logic        shift_en,
  output logic        sdi
);

  logic [FRAME_W-1:0] sr_r;
  logic [CODE_W-1:0]  code_s;

  assign code_s = q31_to_code(tdata, DAC_BITS, OFFSET_BIN != 32'd0);

  // Frame shift register; zeros shift in so the line idles low after a frame.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      sr_r <= {FRAME_W{1'b0}};
    end else if (load_ctrl) begin
      sr_r <= CTRL_WORD;
    end else if (load_data) begin
      sr_r <= {CMD_WRITE, code_s};
    end else if (shift_en) begin
      sr_r <= {sr_r[FRAME_W-2:0], 1'b0};
    end else begin
      sr_r <= sr_r;
    end
  end

  assign sdi = sr_r[FRAME_W-1];

endmodule

// File: rtl/axis_spm_dac_serializer.sv
// Latches four Q31 control outputs on an update tick and drives four parallel
// 20-bit serial DACs over shared SCLK/SYNCn/LDACn, with a one-time init frame.
module axis_spm_dac_serializer
  import spm_dac_pkg::*;
#(
  parameter int unsigned        DAC_BITS      = 32'd20,
  parameter int unsigned        SCLK_HALF     = 32'd2,
  parameter int unsigned        SYNC_GAP      = 32'd4,
  parameter int unsigned        LDAC_W        = 32'd3,
  parameter int unsigned        UPDATE_PERIOD = 32'd128,
  parameter int unsigned        OFFSET_BIN    = 32'd0,
  parameter logic [FRAME_W-1:0] CTRL_WORD     = 24'h200012
) (
  input  logic        a_clk,
  input  logic        a_resetn,
  input  logic [31:0] S_AXIS1_tdata,
  input  logic        S_AXIS1_tvalid,
  input  logic [31:0] S_AXIS2_tdata,
  input  logic        S_AXIS2_tvalid,
  input  logic [31:0] S_AXIS3_tdata,
  input  logic        S_AXIS3_tvalid,
  input  logic [31:0] S_AXIS4_tdata,
  input  logic        S_AXIS4_tvalid,
  input  logic        dac_enable,
  output logic        dac_sclk,
  output logic        dac_syncn,
  output logic [3:0]  dac_sdi,
  output logic        dac_ldacn,
  output logic        busy,
  output logic        overrun,
  output logic [31:0] frame_count
);

  localparam int unsigned PH_W   = $clog2(2 * SCLK_HALF);
  localparam int unsigned CNT_W  = $clog2(SYNC_GAP + LDAC_W + 1);
  localparam int unsigned TICK_W = $clog2(UPDATE_PERIOD);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * SCLK_HALF - 1);
  localparam logic [PH_W-1:0]   PH_HIGH   = PH_W'(SCLK_HALF);
  localparam logic [4:0]        BIT_LAST  = 5'(FRAME_W - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(SYNC_GAP - 1);
  localparam logic [CNT_W-1:0]  LDAC_LAST = CNT_W'(LDAC_W - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UPDATE_PERIOD - 1);

  dac_state_e        state_r, state_s;
  logic [PH_W-1:0]   ph_r, ph_s;
  logic [4:0]        bit_r, bit_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [TICK_W-1:0] tick_cnt_r, tick_cnt_s;
  logic              init_done_r, init_done_s;
  logic              is_init_r, is_init_s;
  logic              en_d_r;
  logic              overrun_r, overrun_s;
  logic [31:0]       frame_count_r, frame_count_s;
  logic              sclk_r, sclk_s;
  logic              syncn_r, syncn_s;
  logic              ldacn_r, ldacn_s;
  logic              busy_r, busy_s;
  logic              tick_s;
  logic              load_ctrl_s, load_data_s, shift_en_s;
  logic              tvalid_unused_s;
  logic [31:0]       tdata_s [4];

  // The current sample is always taken, so tvalid carries no meaning here.
  assign tvalid_unused_s = S_AXIS1_tvalid & S_AXIS2_tvalid & S_AXIS3_tvalid & S_AXIS4_tvalid;

  assign tdata_s[0] = S_AXIS1_tdata;
  assign tdata_s[1] = S_AXIS2_tdata;
  assign tdata_s[2] = S_AXIS3_tdata;
  assign tdata_s[3] = S_AXIS4_tdata;

  assign tick_s = (tick_cnt_r == {TICK_W{1'b0}});

  // Next-state, counters and the next value of every registered output.
  always_comb begin
    state_s       = state_r;
    ph_s          = ph_r;
    bit_s         = bit_r;
    cnt_s         = cnt_r;
    init_done_s   = init_done_r;
    is_init_s     = is_init_r;
    frame_count_s = frame_count_r;
    load_ctrl_s   = 1'b0;
    load_data_s   = 1'b0;
    shift_en_s    = 1'b0;

    if (tick_cnt_r == TICK_LAST) begin
      tick_cnt_s = {TICK_W{1'b0}};
    end else begin
      tick_cnt_s = tick_cnt_r + {{(TICK_W-1){1'b0}}, 1'b1};
    end

    case (state_r)
      ST_IDLE: begin
        if (dac_enable && tick_s) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_ctrl_s = ~init_done_r;
        load_data_s = init_done_r;
        is_init_s   = ~init_done_r;
        ph_s        = {PH_W{1'b0}};
        bit_s       = 5'd0;
        state_s     = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ph_r == PH_LAST) begin
          ph_s       = {PH_W{1'b0}};
          shift_en_s = 1'b1;
          if (bit_r == BIT_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = ST_GAP;
          end else begin
            bit_s = bit_r + 5'd1;
          end
        end else begin
          ph_s = ph_r + {{(PH_W-1){1'b0}}, 1'b1};
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_s = {CNT_W{1'b0}};
          if (!is_init_r) begin
            state_s = ST_LDAC;
          end else if (dac_enable) begin
            init_done_s = 1'b1;
            state_s     = ST_LOAD;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_LDAC: begin
        if (cnt_r == LDAC_LAST) begin
          frame_count_s = frame_count_r + 32'd1;
          state_s       = ST_IDLE;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Losing enable forces the DACs to be re-initialised on the next run.
    if (!dac_enable) begin
      init_done_s = 1'b0;
    end else begin
      init_done_s = init_done_s;
    end

    if (en_d_r && !dac_enable) begin
      overrun_s = 1'b0;
    end else if (tick_s && (state_r != ST_IDLE)) begin
      overrun_s = 1'b1;
    end else begin
      overrun_s = overrun_r;
    end

    syncn_s = (state_s != ST_SHIFT);
    sclk_s  = (state_s == ST_SHIFT) && (ph_s < PH_HIGH);
    ldacn_s = (state_s != ST_LDAC);
    busy_s  = (state_s != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_r       <= ST_IDLE;
      ph_r          <= {PH_W{1'b0}};
      bit_r         <= 5'd0;
      cnt_r         <= {CNT_W{1'b0}};
      tick_cnt_r    <= {TICK_W{1'b0}};
      init_done_r   <= 1'b0;
      is_init_r     <= 1'b0;
      en_d_r        <= 1'b0;
      overrun_r     <= 1'b0;
      frame_count_r <= 32'd0;
      sclk_r        <= 1'b0;
      syncn_r       <= 1'b1;
      ldacn_r       <= 1'b1;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      ph_r          <= ph_s;
      bit_r         <= bit_s;
      cnt_r         <= cnt_s;
      tick_cnt_r    <= tick_cnt_s;
      init_done_r   <= init_done_s;
      is_init_r     <= is_init_s;
      en_d_r        <= dac_enable;
      overrun_r     <= overrun_s;
      frame_count_r <= frame_count_s;
      sclk_r        <= sclk_s;
      syncn_r       <= syncn_s;
      ldacn_r       <= ldacn_s;
      busy_r        <= busy_s;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    spm_dac_lane #(
      .DAC_BITS   (DAC_BITS),
      .OFFSET_BIN (OFFSET_BIN),
      .CTRL_WORD  (CTRL_WORD)
    ) u_lane (
      .a_clk     (a_clk),
      .a_resetn  (a_resetn),
      .tdata     (tdata_s[k]),
      .load_ctrl (load_ctrl_s),
      .load_data (load_data_s),
      .shift_en  (shift_en_s),
      .sdi       (dac_sdi[k])
    );
  end

  assign dac_sclk    = sclk_r;
  assign dac_syncn   = syncn_r;
  assign dac_ldacn   = ldacn_r;
  assign busy        = busy_r;
  assign overrun     = overrun_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_axis_spm_dac_serializer.sv
// Directed bench: three serializer instances (default, offset binary, short update
// period) with a falling-edge frame monitor and hand-computed frame words.
module tb_axis_spm_dac_serializer;

  localparam logic [23:0] CTRL = 24'h200012;

  logic        a_clk = 1'b0;
  logic        a_resetn = 1'b0;
  logic [31:0] x_d = 32'd0, y_d = 32'd0, z_d = 32'd0, u_d = 32'd0;
  logic        tvalid = 1'b1;
  logic [2:0]  en = 3'b000;

  logic [2:0]  sclk_w, syncn_w, ldacn_w, busy_w, ovr_w;
  logic [3:0]  sdi_w [3];
  logic [31:0] fc_w [3];

  int n_tests = 0;
  int n_fail  = 0;

  // monitor state, one slot per instance
  logic [2:0]  sclk_p = 3'b000, syncn_p = 3'b111, ldacn_p = 3'b111;
  logic [23:0] acc_m [3][4];
  logic [23:0] hist [3][16][4];
  int          hist_edges [3][16];
  int          edges_m [3] = '{default: 0};
  int          nfr [3]     = '{default: 0};
  int          nld [3]     = '{default: 0};
  int          ldw_m [3]   = '{default: 0};
  int          ldw_last [3] = '{default: 0};
  int          hi_m [3]    = '{default: 0};
  int          gap_last [3] = '{default: 0};

  always #5 a_clk = ~a_clk;

  axis_spm_dac_serializer dut (
    .a_clk(a_clk), .a_resetn(a_resetn),
    .S_AXIS1_tdata(x_d), .S_AXIS1_tvalid(tvalid), .S_AXIS2_tdata(y_d), .S_AXIS2_tvalid(tvalid),
    .S_AXIS3_tdata(z_d), .S_AXIS3_tvalid(tvalid), .S_AXIS4_tdata(u_d), .S_AXIS4_tvalid(tvalid),
    .dac_enable(en[0]), .dac_sclk(sclk_w[0]), .dac_syncn(syncn_w[0]), .dac_sdi(sdi_w[0]),
    .dac_ldacn(ldacn_w[0]), .busy(busy_w[0]), .overrun(ovr_w[0]), .frame_count(fc_w[0]));

  axis_spm_dac_serializer #(.OFFSET_BIN(1)) dut_ob (
    .a_clk(a_clk), .a_resetn(a_resetn),
    .S_AXIS1_tdata(x_d), .S_AXIS1_tvalid(tvalid), .S_AXIS2_tdata(y_d), .S_AXIS2_tvalid(tvalid),
    .S_AXIS3_tdata(z_d), .S_AXIS3_tvalid(tvalid), .S_AXIS4_tdata(u_d), .S_AXIS4_tvalid(tvalid),
    .dac_enable(en[1]), .dac_sclk(sclk_w[1]), .dac_syncn(syncn_w[1]), .dac_sdi(sdi_w[1]),
    .dac_ldacn(ldacn_w[1]), .busy(busy_w[1]), .overrun(ovr_w[1]), .frame_count(fc_w[1]));

  axis_spm_dac_serializer #(.UPDATE_PERIOD(40)) dut_ov (
    .a_clk(a_clk), .a_resetn(a_resetn),
    .S_AXIS1_tdata(x_d), .S_AXIS1_tvalid(tvalid), .S_AXIS2_tdata(y_d), .S_AXIS2_tvalid(tvalid),
    .S_AXIS3_tdata(z_d), .S_AXIS3_tvalid(tvalid), .S_AXIS4_tdata(u_d), .S_AXIS4_tvalid(tvalid),
    .dac_enable(en[2]), .dac_sclk(sclk_w[2]), .dac_syncn(syncn_w[2]), .dac_sdi(sdi_w[2]),
    .dac_ldacn(ldacn_w[2]), .busy(busy_w[2]), .overrun(ovr_w[2]), .frame_count(fc_w[2]));

  // Frame capture on SCLK falling edges, frame close on SYNCn rising, LDAC/gap widths.
  always @(negedge a_clk) begin
    for (int g = 0; g < 3; g++) begin
      if (sclk_p[g] && !sclk_w[g] && !syncn_w[g]) begin
        for (int l = 0; l < 4; l++) acc_m[g][l] <= {acc_m[g][l][22:0], sdi_w[g][l]};
        edges_m[g] <= edges_m[g] + 1;
      end else if (!syncn_p[g] && syncn_w[g]) begin
        for (int l = 0; l < 4; l++) begin
          hist[g][nfr[g] & 15][l] <= acc_m[g][l];
          acc_m[g][l] <= 24'd0;
        end
        hist_edges[g][nfr[g] & 15] <= edges_m[g];
        nfr[g] <= nfr[g] + 1;
        edges_m[g] <= 0;
      end
      if (!ldacn_w[g]) begin
        ldw_m[g] <= ldw_m[g] + 1;
      end else if (!ldacn_p[g]) begin
        ldw_last[g] <= ldw_m[g];
        nld[g] <= nld[g] + 1;
        ldw_m[g] <= 0;
      end
      if (syncn_w[g]) begin
        hi_m[g] <= hi_m[g] + 1;
      end else begin
        if (syncn_p[g]) gap_last[g] <= hi_m[g];
        hi_m[g] <= 0;
      end
      sclk_p[g]  <= sclk_w[g];
      syncn_p[g] <= syncn_w[g];
      ldacn_p[g] <= ldacn_w[g];
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // kind 0: LDAC pulses, 1: completed frames, 2: falling edges in current frame
  task automatic wait_for(input int kind, input int g, input int target, input int budget, input string tag);
    logic ok;
    int   v;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge a_clk);
      case (kind)
        0:       v = nld[g];
        1:       v = nfr[g];
        default: v = edges_m[g];
      endcase
      if (v >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check_value(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input int g, input int idx,
                             input logic [23:0] e0, input logic [23:0] e1,
                             input logic [23:0] e2, input logic [23:0] e3);
    logic [23:0] ev [4];
    ev = '{e0, e1, e2, e3};
    for (int l = 0; l < 4; l++)
      check_value($sformatf("%s_lane%0d", tag, l), {8'd0, hist[g][idx & 15][l]}, {8'd0, ev[l]});
    check_value($sformatf("%s_edges", tag), hist_edges[g][idx & 15], 32'd24);
  endtask

  initial begin
    int bad;

    // reset values
    repeat (3) @(negedge a_clk);
    check_value("rst_sclk",  {31'd0, sclk_w[0]},  32'd0);
    check_value("rst_syncn", {31'd0, syncn_w[0]}, 32'd1);
    check_value("rst_sdi",   {28'd0, sdi_w[0]},   32'd0);
    check_value("rst_ldacn", {31'd0, ldacn_w[0]}, 32'd1);
    check_value("rst_busy",  {31'd0, busy_w[0]},  32'd0);
    check_value("rst_ovr",   {31'd0, ovr_w[0]},   32'd0);
    check_value("rst_fc",    fc_w[0],             32'd0);

    // init frame, data frame, LDAC; tick fires on the first cycle after release
    x_d = 32'h7FFF_FFFF; y_d = 32'h8000_0000; z_d = 32'h0000_0800; u_d = 32'h0000_07FF;
    en[0] = 1'b1;
    a_resetn = 1'b1;
    @(negedge a_clk);
    check_value("lat_1cyc", {31'd0, syncn_w[0]}, 32'd1);
    @(negedge a_clk);
    check_value("lat_2cyc", {31'd0, syncn_w[0]}, 32'd0);
    wait_for(0, 0, 1, 600, "t1_wait_ldac");
    check_frame("t1_init", 0, 0, CTRL, CTRL, CTRL, CTRL);
    check_frame("t2_data", 0, 1, 24'h17FFFF, 24'h180000, 24'h100001, 24'h100000);
    check_value("t1_gap",   gap_last[0], 32'd5);
    check_value("t1_ldacw", ldw_last[0], 32'd3);
    check_value("t1_fc",    fc_w[0],     32'd1);
    en[0] = 1'b0;

    // offset binary
    x_d = 32'h0000_0000; y_d = 32'h8000_0000; z_d = 32'h0000_0800; u_d = 32'h0000_07FF;
    en[1] = 1'b1;
    wait_for(0, 1, 1, 600, "t3_wait_ldac");
    check_frame("t3_init", 1, 0, CTRL, CTRL, CTRL, CTRL);
    check_frame("t3_data", 1, 1, 24'h180000, 24'h100000, 24'h180001, 24'h180000);
    en[1] = 1'b0;

    // ticks faster than a transfer
    en[2] = 1'b1;
    wait_for(0, 2, 3, 1500, "t4_wait_ldac");
    check_value("t4_ovr_set", {31'd0, ovr_w[2]}, 32'd1);
    check_value("t4_fc",      fc_w[2],           32'd3);
    check_value("t4_nframes", nfr[2],            32'd4);
    bad = 0;
    for (int k = 0; k < 4; k++) if (hist_edges[2][k] != 24) bad++;
    check_value("t4_truncated", bad, 32'd0);
    en[2] = 1'b0;
    @(negedge a_clk);
    check_value("t4_ovr_clr", {31'd0, ovr_w[2]}, 32'd0);

    // enable dropped at bit 10 of a data frame
    x_d = 32'h1234_5678; y_d = 32'hFFFF_F000; z_d = 32'h0000_0000; u_d = 32'hC000_0000;
    en[0] = 1'b1;
    wait_for(1, 0, 3, 600, "t5_wait_init");
    wait_for(2, 0, 10, 200, "t5_wait_bit10");
    en[0] = 1'b0;
    wait_for(0, 0, 2, 300, "t5_wait_ldac");
    check_frame("t5_init", 0, 2, CTRL, CTRL, CTRL, CTRL);
    check_frame("t5_data", 0, 3, 24'h112345, 24'h1FFFFF, 24'h100000, 24'h1C0000);
    check_value("t5_fc", fc_w[0], 32'd2);
    repeat (300) @(negedge a_clk);
    check_value("t5_idle_busy",   {31'd0, busy_w[0]}, 32'd0);
    check_value("t5_idle_frames", nfr[0],             32'd4);
    en[0] = 1'b1;
    wait_for(0, 0, 3, 600, "t5_wait_reen");
    check_frame("t5_reinit", 0, 4, CTRL, CTRL, CTRL, CTRL);
    check_frame("t5_redata", 0, 5, 24'h112345, 24'h1FFFFF, 24'h100000, 24'h1C0000);

    // reset in the middle of a frame
    wait_for(2, 0, 5, 600, "t6_wait_shift");
    #2;
    a_resetn = 1'b0;
    #1;
    check_value("t6_syncn", {31'd0, syncn_w[0]}, 32'd1);
    check_value("t6_sclk",  {31'd0, sclk_w[0]},  32'd0);
    check_value("t6_ldacn", {31'd0, ldacn_w[0]}, 32'd1);
    check_value("t6_fc",    fc_w[0],             32'd0);
    repeat (3) @(negedge a_clk);
    a_resetn = 1'b1;
    wait_for(0, 0, 4, 600, "t6_wait_resume");
    check_frame("t6_init", 0, 7, CTRL, CTRL, CTRL, CTRL);
    check_frame("t6_data", 0, 8, 24'h112345, 24'h1FFFFF, 24'h100000, 24'h1C0000);
    check_value("t6_fc_after", fc_w[0], 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
